// File: rtl/apb_gpio_irq.sv
// ---------------------------------------------------------------------------
// apb_gpio_irq
//
// APB slave GPIO port with WIDTH bidirectional pins. Each pin can be an
// output (driven from ODATA) or an input (high-Z). Every pad is sampled
// through a two-flop synchroniser. Per-pin edge detection sets sticky
// write-1-to-clear status bits, and their OR drives a single irq line.
//
// Register map (word offsets, decoded from PADDR[4:2]):
//   0x00 MODE      RW   1 = pin is an output
//   0x04 ODATA     RW   output value
//   0x08 IDATA     RO   synchronised pad value
//   0x0C INT_EN    RW   per-pin interrupt enable
//   0x10 INT_POL   RW   0 = rising edge, 1 = falling edge
//   0x14 INT_STAT  R/W1C sticky edge status
//   0x18 OSET      WO   ODATA |= data  (GPIO_ATOMIC_SET_CLR_EN only)
//   0x1C OCLR      WO   ODATA &= ~data (GPIO_ATOMIC_SET_CLR_EN only)
//
// Optional feature macro: GPIO_ATOMIC_SET_CLR_EN. When it is undefined,
// 0x18 and 0x1C read 0 and ignore writes.
//
// Ports:
//   PCLK     system clock, rising edge
//   PRESET   synchronous active-high reset
//   PADDR    byte address (ADDR_W bits; only [4:2] decoded)
//   PWRITE   1 = write, 0 = read
//   PSEL     slave select
//   PENABLE  APB access phase
//   PWDATA   write data (low WIDTH bits used)
//   PRDATA   registered read data
//   PREADY   registered transfer-complete strobe (one wait state)
//   gpio     tri-state pads
//   irq      OR of all INT_STAT bits
// ---------------------------------------------------------------------------
module apb_gpio_irq #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PWRITE,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  inout  wire  [WIDTH-1:0]  gpio,
  output logic              irq
);

  typedef enum logic [2:0] {
    REG_MODE     = 3'd0,
    REG_ODATA    = 3'd1,
    REG_IDATA    = 3'd2,
    REG_INT_EN   = 3'd3,
    REG_INT_POL  = 3'd4,
    REG_INT_STAT = 3'd5,
    REG_OSET     = 3'd6,
    REG_OCLR     = 3'd7
  } reg_sel_e;

  reg_sel_e         reg_sel;
  logic [WIDTH-1:0] wdata;
  logic             access;
  logic             wr_commit;
  logic             rd_commit;

  logic [WIDTH-1:0] mode_q;
  logic [WIDTH-1:0] odata_q;
  logic [WIDTH-1:0] int_en_q;
  logic [WIDTH-1:0] int_pol_q;
  logic [WIDTH-1:0] int_stat_q;
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rdata;

  // Upper PWDATA bits and PADDR[1:0] are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{PWDATA, PADDR};

  assign reg_sel = reg_sel_e'(PADDR[4:2]);
  assign wdata   = PWDATA[WIDTH-1:0];

  // The access phase is acted on only while PREADY is low, so each transfer
  // commits exactly once and then gets one cycle of PREADY.
  assign access    = PSEL & PENABLE & ~PREADY;
  assign wr_commit = access & PWRITE;
  assign rd_commit = access & ~PWRITE;

  // Edges come only from the synchroniser and history flops. A change to
  // INT_EN or INT_POL alone therefore never produces a hit.
  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;
  assign hit  = int_en_q & ((int_pol_q & fall) | (~int_pol_q & rise));
  assign clr  = (wr_commit && reg_sel == REG_INT_STAT) ? wdata : '0;

  assign irq = |int_stat_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign gpio[i] = mode_q[i] ? odata_q[i] : 1'bz;
  end

  // Read multiplexer. Bits above WIDTH stay zero.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_MODE:     rdata[WIDTH-1:0] = mode_q;
      REG_ODATA:    rdata[WIDTH-1:0] = odata_q;
      REG_IDATA:    rdata[WIDTH-1:0] = sync2_q;
      REG_INT_EN:   rdata[WIDTH-1:0] = int_en_q;
      REG_INT_POL:  rdata[WIDTH-1:0] = int_pol_q;
      REG_INT_STAT: rdata[WIDTH-1:0] = int_stat_q;
      default:      rdata = '0;
    endcase
  end

  // Bus handshake and control registers. Reset takes priority, so a
  // transfer caught by reset never updates a register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PREADY    <= 1'b0;
      PRDATA    <= '0;
      mode_q    <= '0;
      odata_q   <= '0;
      int_en_q  <= '0;
      int_pol_q <= '0;
    end else begin
      PREADY <= access;
      if (rd_commit) begin
        PRDATA <= rdata;
      end
      if (wr_commit) begin
        case (reg_sel)
          REG_MODE:    mode_q    <= wdata;
          REG_ODATA:   odata_q   <= wdata;
          REG_INT_EN:  int_en_q  <= wdata;
          REG_INT_POL: int_pol_q <= wdata;
`ifdef GPIO_ATOMIC_SET_CLR_EN
          REG_OSET:    odata_q   <= odata_q | wdata;
          REG_OCLR:    odata_q   <= odata_q & ~wdata;
`endif
          default: ;
        endcase
      end
    end
  end

  // Input synchroniser, edge history and sticky status. A hit and a clear
  // on the same bit in the same cycle leave the bit set.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      int_stat_q <= '0;
    end else begin
      sync1_q    <= gpio;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      int_stat_q <= (int_stat_q & ~clr) | hit;
    end
  end

endmodule

// File: tb/tb_apb_gpio_irq.sv
// ---------------------------------------------------------------------------
// tb_apb_gpio_irq
//
// Directed bench for apb_gpio_irq (WIDTH=8). Each read pushes its
// hand-computed expected value onto a queue. A monitor pops and compares
// whenever the DUT completes a read (PREADY high with PWRITE low). Pad and
// irq levels are compared directly. The pads carry pull-ups, so an undriven
// (high-Z) pin reads as 1.
// ---------------------------------------------------------------------------
module tb_apb_gpio_irq;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  logic        PCLK;
  logic        PRESET;
  logic [4:0]  PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  wire  [7:0]  gpio;
  logic        irq;

  logic [7:0]  padDrive;
  logic [7:0]  padEn;

  exp_t        expQ[$];
  int          checkCount;
  int          errorCount;
  logic        readyLast;

`ifdef GPIO_ATOMIC_SET_CLR_EN
  localparam logic [31:0] ODATA_AFTER_SET = 32'h0000_00F3;
  localparam logic [31:0] ODATA_AFTER_CLR = 32'h0000_00C3;
`else
  localparam logic [31:0] ODATA_AFTER_SET = 32'h0000_00F0;
  localparam logic [31:0] ODATA_AFTER_CLR = 32'h0000_00F0;
`endif

  apb_gpio_irq #(.WIDTH(8), .ADDR_W(5)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .gpio    (gpio),
    .irq     (irq)
  );

  // The bench drives a pad only while its enable bit is set; otherwise the
  // pull-up makes a released pin read 1.
  for (genvar i = 0; i < 8; i++) begin : g_tbpad
    assign gpio[i] = padEn[i] ? padDrive[i] : 1'bz;
    pullup (gpio[i]);
  end

  // Free-running 10-time-unit clock.
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Monitor: on each falling edge, a completed read is scored against the
  // next queued expectation. A PREADY pulse longer than one cycle is an error.
  always @(negedge PCLK) begin
    if (!PRESET && PREADY) begin
      checkCount++;
      if (readyLast) begin
        errorCount++;
        $display("[TB] FAIL pready_width actual=2+ cycles required=1 cycle");
      end
      if (!PWRITE) begin
        if (expQ.size() == 0) begin
          checkCount++;
          errorCount++;
          $display("[TB] FAIL unexpected_read actual=%h required=no read", PRDATA);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkCount++;
          if (PRDATA !== e.value) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h required=%h", e.name, PRDATA, e.value);
          end
        end
      end
    end
    readyLast = PREADY && !PRESET;
  end

  // Direct level comparison for pads, irq and other non-bus signals.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // One APB transfer. The task is entered and left just after a rising
  // edge. A read pushes its expected data before the bus is driven, so the
  // access edge is the second rising edge after entry.
  task automatic applyStimulus(input logic [4:0] addr, input logic wr,
                               input logic [31:0] data, input string name);
    bit done;
    if (!wr) expQ.push_back('{name: name, value: data});
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wr ? data : 32'h0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 4 && !done; k++) begin
      @(posedge PCLK); #1;
      if (PREADY) done = 1'b1;
    end
    if (!done) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL pready_timeout actual=0 required=1 (%s)", name);
    end
    @(posedge PCLK); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK); #1;
    end
  endtask

  // Directed test sequence.
  initial begin
    logic [4:0] a;
    checkCount = 0;
    errorCount = 0;
    readyLast  = 1'b0;
    PRESET   = 1'b1;
    PSEL     = 1'b0;
    PENABLE  = 1'b0;
    PWRITE   = 1'b0;
    PADDR    = '0;
    PWDATA   = '0;
    padDrive = 8'h00;
    padEn    = 8'hFF;

    // Reset with the pads held low, so IDATA also reads 0.
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    checkOutput("reset_pready", {31'b0, PREADY}, 32'h0);
    checkOutput("reset_prdata", PRDATA, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      a = 5'(i * 4);
      applyStimulus(a, 1'b0, 32'h0, $sformatf("reset_read_%0h", a));
    end

    // Released pads must be high-Z, so the pull-ups read 1.
    padEn = 8'h00;
    idle(1);
    checkOutput("reset_gpio_z", {24'b0, gpio}, 32'h0000_00FF);

    // Low nibble driven from ODATA, high nibble left floating.
    applyStimulus(5'h00, 1'b1, 32'h0000_000F, "wr_mode");
    applyStimulus(5'h04, 1'b1, 32'h0000_00A5, "wr_odata");
    checkOutput("gpio_mode_0f", {24'b0, gpio}, 32'h0000_00F5);
    applyStimulus(5'h04, 1'b0, 32'h0000_00A5, "rd_odata_a5");
    applyStimulus(5'h00, 1'b0, 32'h0000_000F, "rd_mode_0f");

    // All inputs; the pads switch 0x00 -> 0x3C as the read is set up.
    applyStimulus(5'h00, 1'b1, 32'h0, "wr_mode_0");
    padDrive = 8'h00;
    padEn    = 8'hFF;
    idle(3);
    padDrive = 8'h3C;
    applyStimulus(5'h08, 1'b0, 32'h0000_0000, "idata_before_sync");
    applyStimulus(5'h08, 1'b0, 32'h0000_003C, "idata_after_sync");

    // Rising-edge interrupt on pin 0, visible three edges after the change.
    applyStimulus(5'h0C, 1'b1, 32'h0000_0001, "wr_int_en");
    applyStimulus(5'h10, 1'b1, 32'h0000_0000, "wr_int_pol");
    padDrive = 8'h3D;
    idle(2);
    checkOutput("irq_two_edges", {31'b0, irq}, 32'h0);
    idle(1);
    checkOutput("irq_three_edges", {31'b0, irq}, 32'h1);
    applyStimulus(5'h14, 1'b0, 32'h0000_0001, "int_stat_rise");
    applyStimulus(5'h14, 1'b1, 32'h0000_0001, "w1c_bit0");
    applyStimulus(5'h14, 1'b0, 32'h0000_0000, "int_stat_cleared");
    checkOutput("irq_cleared", {31'b0, irq}, 32'h0);
    padDrive = 8'h3C;
    idle(5);
    applyStimulus(5'h14, 1'b0, 32'h0000_0000, "fall_ignored_rise_pol");
    applyStimulus(5'h10, 1'b1, 32'h0000_0001, "wr_pol_only");
    idle(3);
    applyStimulus(5'h14, 1'b0, 32'h0000_0000, "pol_change_no_hit");

    // Falling edge on pin 7 lands on the same edge as its W1C write.
    padDrive = 8'hBC;
    idle(4);
    applyStimulus(5'h10, 1'b1, 32'h0000_0080, "wr_pol_fall");
    applyStimulus(5'h0C, 1'b1, 32'h0000_0080, "wr_en_7");
    padDrive = 8'h3C;
    idle(1);
    applyStimulus(5'h14, 1'b1, 32'h0000_0080, "w1c_coincident");
    applyStimulus(5'h14, 1'b0, 32'h0000_0080, "set_beats_clear");
    checkOutput("irq_coincident", {31'b0, irq}, 32'h1);
    applyStimulus(5'h14, 1'b1, 32'h0000_0080, "w1c_bit7");
    applyStimulus(5'h14, 1'b0, 32'h0000_0000, "int_stat_bit7_cleared");

    // Atomic set/clear (or their absence in the default build).
    applyStimulus(5'h04, 1'b1, 32'h0000_00F0, "wr_odata_f0");
    applyStimulus(5'h18, 1'b1, 32'h0000_0003, "wr_oset");
    applyStimulus(5'h04, 1'b0, ODATA_AFTER_SET, "odata_after_oset");
    applyStimulus(5'h1C, 1'b1, 32'h0000_0030, "wr_oclr");
    applyStimulus(5'h04, 1'b0, ODATA_AFTER_CLR, "odata_after_oclr");
    applyStimulus(5'h18, 1'b0, 32'h0000_0000, "rd_oset_zero");
    applyStimulus(5'h1C, 1'b0, 32'h0000_0000, "rd_oclr_zero");

    // All outputs, with upper write bits discarded.
    padEn = 8'h00;
    idle(1);
    applyStimulus(5'h00, 1'b1, 32'hFFFF_FFFF, "wr_mode_all");
    applyStimulus(5'h00, 1'b0, 32'h0000_00FF, "rd_mode_masked");
    checkOutput("gpio_all_out", {24'b0, gpio}, ODATA_AFTER_CLR);

    // Reset lands on the access edge of a write.
    PSEL   = 1'b1;
    PWRITE = 1'b1;
    PADDR  = 5'h04;
    PWDATA = 32'h0000_0055;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    PRESET  = 1'b1;
    @(posedge PCLK); #1;
    checkOutput("reset_abort_pready", {31'b0, PREADY}, 32'h0);
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    idle(1);
    checkOutput("reset_abort_gpio_z", {24'b0, gpio}, 32'h0000_00FF);
    checkOutput("reset_abort_irq", {31'b0, irq}, 32'h0);
    applyStimulus(5'h04, 1'b0, 32'h0000_0000, "odata_after_abort");
    applyStimulus(5'h00, 1'b0, 32'h0000_0000, "mode_after_abort");

    idle(4);
    checkOutput("scoreboard_drained", expQ.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/apb_gpio_irq.md
Name: apb_gpio_irq

Overview:
- Parametrised APB slave GPIO port. Generalises the 4-bit output-only GPO to WIDTH bidirectional pins.
- Adds synchronised input readback, per-pin edge-detect interrupts with sticky write-1-to-clear status, and a single combined irq line.
- Sits on the APB bus beside the other peripherals. Pads connect directly through a tri-state inout.

Parameters:
- WIDTH, 8, number of GPIO pins (1..32).
- ADDR_W, 5, PADDR width. Decode uses PADDR[4:2] only; PADDR[1:0] ignored.

Ports:
- PCLK  in  1  system clock; all logic on rising edge.
- PRESET  in  1  synchronous active-high reset.
- PADDR  in  ADDR_W  byte address.
- PWRITE  in  1  1=write, 0=read.
- PSEL  in  1  slave select.
- PENABLE  in  1  APB access phase.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, registered.
- PREADY  out  1  transfer complete, registered.
- gpio  inout  WIDTH  pads. Bit i is driven with ODATA[i] when MODE[i]=1, else high-Z.
- irq  out  1  OR of INT_STAT bits.

Behaviour:
- Register map, 32-bit word offsets:
  - 0x00 MODE, RW, 1=output.
  - 0x04 ODATA, RW.
  - 0x08 IDATA, RO; writes ignored.
  - 0x0C INT_EN, RW.
  - 0x10 INT_POL, RW; 0=rising, 1=falling.
  - 0x14 INT_STAT, read / write-1-to-clear.
  - 0x18, 0x1C: see Optional Feature.
- Register bits [31:WIDTH] read 0. Writes use PWDATA[WIDTH-1:0].
- Reset (sync, PRESET=1 at a rising edge) clears all of the following to 0:
  - all registers, PRDATA, PREADY, synchroniser and history flops, irq.
  - gpio is all high-Z.
  - Reset mid-transfer aborts it: no register update, PREADY=0 next cycle.
- APB handshake, exactly one wait state per transfer:
  - Edge with PSEL&PENABLE&!PREADY: perform the write, or load PRDATA from the addressed register; set PREADY<=1.
  - Next edge: PREADY<=0 unconditionally. The master sees completion in the cycle PREADY=1.
  - PSEL without PENABLE (setup phase) has no effect.
  - PRDATA holds its last value outside reads.
  - Writes become visible on pads the cycle after the commit edge.
- Input path:
  - sync1<=gpio, sync2<=sync1 (2-FF synchroniser); prev<=sync2.
  - IDATA = sync2. Pad-to-IDATA latency is 2 edges.
  - Output-mode pins also read back their driven pad value.
- Edge detect per bit i:
  - rise = sync2 & ~prev; fall = ~sync2 & prev.
  - hit[i] = INT_EN[i] & (INT_POL[i] ? fall[i] : rise[i]).
  - Pad-to-INT_STAT latency is 3 edges.
- INT_STAT update:
  - INT_STAT <= (INT_STAT & ~clr) | hit, where clr = PWDATA bits on a committed write to 0x14.
  - A set and a clear on the same bit in the same cycle leaves the bit set.
  - Clearing INT_EN does not clear pending status.
- irq = |INT_STAT, driven combinationally from the status flops.
- Changing INT_POL or INT_EN never creates a spurious hit on its own; hits come only from sync2/prev transitions.

Optional Feature:
- Macro: GPIO_ATOMIC_SET_CLR_EN.
- Defined:
  - 0x18 OSET: write sets ODATA |= PWDATA[WIDTH-1:0].
  - 0x1C OCLR: write sets ODATA &= ~PWDATA[WIDTH-1:0].
  - Both registers read 0.
- Not defined: 0x18/0x1C read 0, writes are ignored, and ODATA changes only via 0x04.
- The handshake is identical in both builds.

Test Plan:
- Reset, then read every offset -> PRDATA=0 each time, PREADY high exactly 1 cycle per transfer, gpio all Z, irq=0.
- Write MODE=0x0F, ODATA=0xA5 -> gpio[3:0]=4'h5 driven, gpio[7:4]=Z. Read ODATA -> 0x000000A5.
- MODE=0, bench drives gpio=0x3C -> IDATA read returns 0x3C only after the 2-edge sync delay. Check a read issued 1 cycle after the pad change still returns the old value.
- INT_EN=0x01, INT_POL=0, pad[0] 0->1 -> INT_STAT=0x01 and irq=1 three edges later. Pad[0] 1->0 -> no new event. Write 0x14=0x01 -> INT_STAT=0, irq=0.
- INT_EN=0x80, INT_POL=0x80, pad[7] falls, timed so the detected edge coincides with a W1C write of 0x80 -> INT_STAT[7] remains 1.
- With GPIO_ATOMIC_SET_CLR_EN: ODATA=0xF0, write OSET=0x03 -> 0xF3, then OCLR=0x30 -> 0xC3. Without the macro, the same writes leave ODATA=0xF0.
